// File: rtl/generation_sequencer.sv
// generation_sequencer: turns timer ticks and single-step edges into one req/ack/done
// handshake per accepted go; define OVERRUN_CNT_EN to count dropped gos.
module generation_sequencer #(
    parameter int GEN_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic             i_run_en,
    input  logic             i_step_in,
    input  logic             i_clear_gen,
    input  logic             i_step_ack,
    input  logic             i_engine_done,
    output logic             o_step_req,
    output logic             o_busy,
    output logic [GEN_W-1:0] o_gen_count,
    output logic [GEN_W-1:0] o_overrun_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t           r_state, w_next;
    logic             r_step_d, r_run_d, r_pending, r_step_req, r_busy;
    logic [GEN_W-1:0] r_gen;
    logic             w_go, w_fall, w_drop, w_pending_next;
    assign w_go   = (i_tick & i_run_en) | (i_step_in & ~r_step_d & ~i_run_en);
    assign w_fall = r_run_d & ~i_run_en;
    // a go arriving while already holding a buffered one is lost
    assign w_drop = (r_state != IDLE) & w_go & r_pending & ~w_fall;
    assign w_pending_next = w_fall ? 1'b0 :
                            (r_state == IDLE) ? (r_pending & w_go) : (r_pending | w_go);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_go | r_pending) w_next = REQ;
            REQ:     if (i_step_ack) w_next = WAIT;
            WAIT:    if (i_engine_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_step_req <= 1'b0;
            r_busy     <= 1'b0;
            r_pending  <= 1'b0;
            r_step_d   <= 1'b0;
            r_run_d    <= 1'b0;
            r_gen      <= '0;
        end else begin
            r_state    <= w_next;
            r_step_req <= (w_next == REQ);
            r_busy     <= (w_next != IDLE);
            r_pending  <= w_pending_next;
            r_step_d   <= i_step_in;
            r_run_d    <= i_run_en;
            r_gen      <= i_clear_gen ? '0 :
                          (r_state == WAIT && i_engine_done) ? r_gen + 1'b1 : r_gen;
        end
    end
`ifdef OVERRUN_CNT_EN
    logic [GEN_W-1:0] r_overrun;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_overrun <= '0;
        else r_overrun <= i_clear_gen ? '0 : w_drop ? r_overrun + 1'b1 : r_overrun;
    end
    assign o_overrun_cnt = r_overrun;
`else
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
    assign o_overrun_cnt = '0;
`endif
    assign o_step_req  = r_step_req;
    assign o_busy      = r_busy;
    assign o_gen_count = r_gen;
endmodule
